// File: rtl/break_select_sequencer_pkg.sv
// Shared definitions for the break-select sequencer: FSM encoding, wren codes and
// configuration sanity checks used by the top and its tag pipe.
package break_select_sequencer_pkg;

    localparam int DEF_MC         = 20;
    localparam int DEF_NSAT       = 3;
    localparam int DEF_NSAT_BITS  = 2;
    localparam int DEF_COUNT_LAT  = 1;
    localparam int DEF_RESULT_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Wide forms; users truncate to their NSAT_BITS width.
    localparam logic [31:0] WREN_IDLE   = 32'h0000_0000;
    localparam logic [31:0] WREN_SELECT = 32'hFFFF_FFFF;

    function automatic logic [31:0] wren_onehot(input int k);
        return 32'd1 << k;
    endfunction

    function automatic bit cfg_ok(input int mc, input int nsat, input int nsat_bits,
                                  input int count_lat, input int result_lat);
        return (mc >= 1) && (nsat >= 2) && (nsat_bits == nsat - 1) && (nsat_bits <= 32) &&
               (count_lat >= 1) && (result_lat >= 2) && (count_lat + result_lat < 255);
    endfunction

endpackage

// File: rtl/break_select_sequencer_tag_pipe.sv
// COUNT_LAT-deep delay line that carries wren tags alongside the counter latency;
// a synchronous flush zeroes every stage so an aborted job leaves no wren behind.
module break_select_tag_pipe
    import break_select_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_NSAT_BITS,
    parameter int DEPTH = DEF_COUNT_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) stage_d[i] = WIDTH'(WREN_IDLE);
        if (!flush_i) begin
            stage_d[0] = tag_i;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/break_select_sequencer.sv
// Feeds NSAT candidate rows to the break counter/selector, sequences wren and returns one result.
// Optional macro BREAK_SELECT_SEQ_STATS_EN adds saturating job/stall counters.
module break_select_sequencer
    import break_select_sequencer_pkg::*;
#(
    parameter int MAX_CLAUSES_PER_VARIABLE = DEF_MC,
    parameter int NSAT                     = DEF_NSAT,
    parameter int NSAT_BITS                = DEF_NSAT_BITS,
    parameter int COUNT_LAT                = DEF_COUNT_LAT,
    parameter int RESULT_LAT               = DEF_RESULT_LAT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                abort_i,
    input  logic                                row_valid_i,
    output logic                                row_ready_o,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] row_clause_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] row_mask_i,
    input  logic                                row_var_valid_i,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
    output logic [NSAT_BITS-1:0]                wren_o,
    output logic [NSAT-1:0]                     break_values_valid_o,
    input  logic [NSAT_BITS-1:0]                select_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_bits_i,
    output logic                                result_valid_o,
    input  logic                                result_ready_i,
    output logic [NSAT_BITS-1:0]                result_select_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] result_clause_bits_o,
    output logic                                result_none_o,
    output logic                                busy_o
`ifdef BREAK_SELECT_SEQ_STATS_EN
    ,
    output logic [31:0]                         stat_jobs_o,
    output logic [31:0]                         stat_stall_o
`endif
);

    localparam int MC    = MAX_CLAUSES_PER_VARIABLE;
    localparam int ROW_W = $clog2(NSAT);
    localparam logic [ROW_W-1:0]     LAST_ROW   = ROW_W'(NSAT - 1);
    localparam logic [NSAT_BITS-1:0] WREN_SEL   = NSAT_BITS'(WREN_SELECT);
    localparam logic [NSAT_BITS-1:0] WREN_ZERO  = NSAT_BITS'(WREN_IDLE);
    localparam logic [7:0]           SAMPLE_CNT = 8'(COUNT_LAT + RESULT_LAT);

    if (!cfg_ok(MC, NSAT, NSAT_BITS, COUNT_LAT, RESULT_LAT)) begin : g_bad_cfg
        $error("break_select_sequencer: inconsistent NSAT/NSAT_BITS/latency parameters");
    end

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      row_idx_q, row_idx_d;
    logic                  row_ready_q, row_ready_d;
    logic [MC-1:0]         cb_q, cb_d, mask_q, mask_d;
    logic [NSAT_BITS-1:0]  tag_issue_q, tag_issue_d;
    logic [NSAT-1:0]       bvv_q, bvv_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  res_valid_q, res_valid_d, res_none_q, res_none_d;
    logic [NSAT_BITS-1:0]  res_sel_q, res_sel_d;
    logic [MC-1:0]         res_bits_q, res_bits_d;

    logic row_accept, last_row, result_hs;

    assign row_accept = row_valid_i && row_ready_q && !abort_i;
    assign last_row   = (row_idx_q == LAST_ROW);
    assign result_hs  = (state_q == ST_DONE) && result_ready_i && !abort_i;

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        cb_d        = '0;
        mask_d      = '0;
        tag_issue_d = WREN_ZERO;
        bvv_d       = bvv_q;
        wait_cnt_d  = '0;
        res_valid_d = res_valid_q;
        res_sel_d   = res_sel_q;
        res_bits_d  = res_bits_q;
        res_none_d  = res_none_q;

        if (row_accept) begin
            cb_d        = row_clause_broken_i;
            mask_d      = row_mask_i;
            tag_issue_d = last_row ? WREN_SEL : NSAT_BITS'(wren_onehot(int'(row_idx_q)));
            if (row_idx_q == '0) bvv_d = '0;
            for (int k = 0; k < NSAT; k++) begin
                if (row_idx_q == ROW_W'(k)) bvv_d[k] = row_var_valid_i;
            end
            row_idx_d = last_row ? '0 : row_idx_q + 1'b1;
            state_d   = last_row ? ST_WAIT : ST_LOAD;
        end

        // WAIT is entered the cycle after the last row, so the all-ones wren cycle
        // lands at count COUNT_LAT and the selector output is valid RESULT_LAT later.
        case (state_q)
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_q == SAMPLE_CNT) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_none_d  = ~|bvv_q;
                    res_sel_d   = (~|bvv_q) ? WREN_ZERO : select_i;
                    res_bits_d  = clause_broken_bits_i;
                end
            end
            ST_DONE: begin
                if (result_ready_i) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (abort_i) begin
            state_d     = ST_IDLE;
            row_idx_d   = '0;
            tag_issue_d = WREN_ZERO;
            bvv_d       = '0;
            wait_cnt_d  = '0;
            res_valid_d = 1'b0;
        end

        row_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_idx_q   <= '0;
            row_ready_q <= 1'b0;
            cb_q        <= '0;
            mask_q      <= '0;
            tag_issue_q <= '0;
            bvv_q       <= '0;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_sel_q   <= '0;
            res_bits_q  <= '0;
            res_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            row_ready_q <= row_ready_d;
            cb_q        <= cb_d;
            mask_q      <= mask_d;
            tag_issue_q <= tag_issue_d;
            bvv_q       <= bvv_d;
            wait_cnt_q  <= wait_cnt_d;
            res_valid_q <= res_valid_d;
            res_sel_q   <= res_sel_d;
            res_bits_q  <= res_bits_d;
            res_none_q  <= res_none_d;
        end
    end

    break_select_tag_pipe #(
        .WIDTH (NSAT_BITS),
        .DEPTH (COUNT_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (abort_i),
        .tag_i   (tag_issue_q),
        .tag_o   (wren_o)
    );

    assign row_ready_o          = row_ready_q;
    assign clause_broken_o      = cb_q;
    assign mask_bits_o          = mask_q;
    assign break_values_valid_o = bvv_q;
    assign result_valid_o       = res_valid_q;
    assign result_select_o      = res_sel_q;
    assign result_clause_bits_o = res_bits_q;
    assign result_none_o        = res_none_q;
    assign busy_o               = (state_q != ST_IDLE);

`ifdef BREAK_SELECT_SEQ_STATS_EN
    logic [31:0] jobs_q, jobs_d, stall_q, stall_d;

    always_comb begin
        jobs_d  = jobs_q;
        stall_d = stall_q;
        if (result_hs && (jobs_q != 32'hFFFF_FFFF)) jobs_d = jobs_q + 32'd1;
        if ((((state_q == ST_LOAD) && !row_valid_i) || ((state_q == ST_DONE) && !result_ready_i))
            && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jobs_q  <= '0;
            stall_q <= '0;
        end else begin
            jobs_q  <= jobs_d;
            stall_q <= stall_d;
        end
    end

    assign stat_jobs_o  = jobs_q;
    assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_break_select_sequencer.sv
// Directed bench for break_select_sequencer: wren sequencing, bubbles, empty jobs,
// abort, async reset and (with BREAK_SELECT_SEQ_STATS_EN) the statistics counters.
module tb_break_select_sequencer;

    localparam int MC = 20;
    localparam logic [MC-1:0] R0C = 20'h0F0F1;
    localparam logic [MC-1:0] R1C = 20'hA0A02;
    localparam logic [MC-1:0] R2C = 20'h33C03;
    localparam logic [MC-1:0] MSK = 20'hFFF0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, abort_i, row_valid, row_ready, var_valid;
    logic          result_ready, result_valid, result_none, busy;
    logic [MC-1:0] row_cb, row_mask, cb_o, mask_o, sel_bits, res_bits;
    logic [1:0]    wren, select, res_sel;
    logic [2:0]    bvv;
`ifdef BREAK_SELECT_SEQ_STATS_EN
    logic [31:0]   stat_jobs, stat_stall;
`endif

    int n_err    = 0;
    int n_checks = 0;

    break_select_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .abort_i              (abort_i),
        .row_valid_i          (row_valid),
        .row_ready_o          (row_ready),
        .row_clause_broken_i  (row_cb),
        .row_mask_i           (row_mask),
        .row_var_valid_i      (var_valid),
        .clause_broken_o      (cb_o),
        .mask_bits_o          (mask_o),
        .wren_o               (wren),
        .break_values_valid_o (bvv),
        .select_i             (select),
        .clause_broken_bits_i (sel_bits),
        .result_valid_o       (result_valid),
        .result_ready_i       (result_ready),
        .result_select_o      (res_sel),
        .result_clause_bits_o (res_bits),
        .result_none_o        (result_none),
        .busy_o               (busy)
`ifdef BREAK_SELECT_SEQ_STATS_EN
        ,
        .stat_jobs_o          (stat_jobs),
        .stat_stall_o         (stat_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input logic v, input logic [MC-1:0] cb, input logic vv);
        row_valid = v;
        row_cb    = cb;
        row_mask  = MSK;
        var_valid = vv;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
    endtask

    task automatic run_job(input string tag, input logic [2:0] vv, input logic [1:0] sel,
                           input int hold, input logic row_on_ack);
        select       = sel;
        sel_bits     = 20'h5A5A0 | 20'(sel);
        result_ready = 1'b0;
        set_row(1'b1, R0C, vv[0]); tick();
        set_row(1'b1, R1C, vv[1]); tick();
        set_row(1'b1, R2C, vv[2]); tick();
        set_row(1'b0, '0, 1'b0);
        wait_result(tag);
        check({tag, "_none"}, 32'(result_none), (vv == 3'd0) ? 32'd1 : 32'd0);
        check({tag, "_sel"}, 32'(res_sel), (vv == 3'd0) ? 32'd0 : 32'(sel));
        check({tag, "_bits"}, 32'(res_bits), 32'(20'h5A5A0 | 20'(sel)));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, 32'(result_valid), 32'd1);
        end
        result_ready = 1'b1;
        row_valid    = row_on_ack;
        tick();
        check({tag, "_ack"}, 32'(result_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_no_row"}, 32'(cb_o), 32'd0);
        result_ready = 1'b0;
        row_valid    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; abort_i = 1'b0; result_ready = 1'b0;
        select = 2'd0; sel_bits = '0;
        set_row(1'b0, '0, 1'b0);

        // reset state
        tick(); tick();
        check("rst_ready", 32'(row_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_rvalid", 32'(result_valid), 32'd0);
        reset = 1'b1;
        tick();
        check("rel_ready", 32'(row_ready), 32'd1);

        // back-to-back rows, selector stub answers 2
        select = 2'd2; sel_bits = 20'h12345; result_ready = 1'b1;
        set_row(1'b1, R0C, 1'b1); tick();
        check("t1_cb0", 32'(cb_o), 32'(R0C));
        check("t1_mask0", 32'(mask_o), 32'(MSK));
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_wren_a", 32'(wren), 32'd0);
        set_row(1'b1, R1C, 1'b1); tick();
        check("t1_wren_01", 32'(wren), 32'd1);
        set_row(1'b1, R2C, 1'b1); tick();
        check("t1_wren_10", 32'(wren), 32'd2);
        check("t1_ready_lo", 32'(row_ready), 32'd0);
        set_row(1'b0, '0, 1'b0); tick();
        check("t1_wren_11", 32'(wren), 32'd3);
        check("t1_bvv", 32'(bvv), 32'd7);
        tick();
        check("t1_wren_00", 32'(wren), 32'd0);
        tick();
        check("t1_not_yet", 32'(result_valid), 32'd0);
        tick();
        check("t1_rvalid", 32'(result_valid), 32'd1);
        check("t1_rsel", 32'(res_sel), 32'd2);
        check("t1_rbits", 32'(res_bits), 32'h12345);
        check("t1_rnone", 32'(result_none), 32'd0);
        tick();
        check("t1_ack", 32'(result_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_ready", 32'(row_ready), 32'd1);

        // bubble between row0 and row1
        set_row(1'b1, R0C, 1'b1); tick();
        set_row(1'b0, '0, 1'b0); tick();
        check("t2_wren_01", 32'(wren), 32'd1);
        check("t2_bubble_cb", 32'(cb_o), 32'd0);
        set_row(1'b1, R1C, 1'b1); tick();
        check("t2_wren_00", 32'(wren), 32'd0);
        set_row(1'b1, R2C, 1'b1); tick();
        check("t2_wren_10", 32'(wren), 32'd2);
        set_row(1'b0, '0, 1'b0); tick();
        check("t2_wren_11", 32'(wren), 32'd3);
        check("t2_bvv", 32'(bvv), 32'd7);
        wait_result("t2");
        check("t2_rsel", 32'(res_sel), 32'd2);
        tick();
        check("t2_ack", 32'(result_valid), 32'd0);

        // no valid candidates, 5-cycle downstream stall, row offered on handshake
        run_job("t3", 3'b000, 2'd2, 5, 1'b1);

        // abort one cycle after row1 accepted
        select = 2'd1;
        set_row(1'b1, R0C, 1'b1); tick();
        set_row(1'b1, R1C, 1'b1); tick();
        set_row(1'b1, R2C, 1'b1); abort_i = 1'b1; tick();
        abort_i = 1'b0; set_row(1'b0, '0, 1'b0);
        check("t4_wren", 32'(wren), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_bvv", 32'(bvv), 32'd0);
        check("t4_ready", 32'(row_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_no_result", 32'(result_valid), 32'd0);
            check("t4_wren_idle", 32'(wren), 32'd0);
        end
        run_job("t4_next", 3'b010, 2'd1, 0, 1'b0);

        // async reset in WAIT
        select = 2'd2;
        set_row(1'b1, R0C, 1'b1); tick();
        set_row(1'b1, R1C, 1'b1); tick();
        set_row(1'b1, R2C, 1'b1); tick();
        set_row(1'b0, '0, 1'b0);
        check("t5_wren_pre", 32'(wren), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("t5_wren", 32'(wren), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(row_ready), 32'd0);
        check("t5_cb", 32'(cb_o), 32'd0);
        check("t5_bvv", 32'(bvv), 32'd0);
        tick();
        check("t5_hold_ready", 32'(row_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("t5_rel_ready", 32'(row_ready), 32'd1);
        check("t5_rel_rvalid", 32'(result_valid), 32'd0);

        // four jobs, three stall cycles in total
`ifdef BREAK_SELECT_SEQ_STATS_EN
        check("st_jobs_rst", stat_jobs, 32'd0);
        check("st_stall_rst", stat_stall, 32'd0);
`endif
        run_job("j1", 3'b111, 2'd0, 0, 1'b0);
        run_job("j2", 3'b100, 2'd2, 3, 1'b0);
        run_job("j3", 3'b001, 2'd0, 0, 1'b0);
        run_job("j4", 3'b011, 2'd1, 0, 1'b0);
`ifdef BREAK_SELECT_SEQ_STATS_EN
        check("st_jobs", stat_jobs, 32'd4);
        check("st_stall", stat_stall, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
